satatx_crc_scrambler: RTL and testbench
=======================================

Name: satatx_crc_scrambler

Overview:
Transmit-side frame stage for the SATA link layer. It takes raw FIS dwords from the transport layer and computes the SATA CRC-32 over them. It appends that CRC as a final dword, then scrambles both data and CRC with the SATA 16-bit LFSR before handing the frame to the primitive/8b10b path. It mirrors the receive-side descrambler and uses the same LFSR polynomial, seed and bit ordering.

Parameters:
POLYNOMIAL, 16'ha011, scrambler LFSR feedback taps (x^16+x^15+x^13+x^4+1).
INITIAL, 16'hffff, scrambler seed at every frame start.
CRC_POLY, 32'h04c11db7, CRC-32 generator, non-reflected, MSB first.
CRC_INIT, 32'h52325032, SATA CRC seed at every frame start.
OPT_LOWPOWER, 1'b1, forces M_AXIS_TDATA/TLAST to zero whenever M_AXIS_TVALID is low.

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESET  in  1  synchronous, active-high reset
i_cfg_scrambler_en  in  1  1 = scramble; 0 = pass data and CRC unscrambled
S_AXIS_TVALID  in  1  raw FIS dword valid
S_AXIS_TREADY  out  1  accept
S_AXIS_TDATA  in  32  raw dword
S_AXIS_TLAST  in  1  last dword of FIS
S_AXIS_TABORT  in  1  source abandons current frame
M_AXIS_TVALID  out  1  scrambled dword valid
M_AXIS_TREADY  in  1  downstream accept
M_AXIS_TDATA  out  32  scrambled data or CRC
M_AXIS_TLAST  out  1  set only on the CRC beat
M_AXIS_TABORT  out  1  frame aborted downstream

Behaviour:
- Reset values: M_AXIS_TVALID=0, M_AXIS_TABORT=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0.
- Reset also sets: state=IDLE, fill=INITIAL, crc=CRC_INIT.
- Reset takes effect mid-frame; any partial frame is dropped silently, with no abort emitted.
- State machine: IDLE, DATA, CRC.
  - IDLE→DATA on the first accepted beat without TLAST.
  - IDLE or DATA → CRC on an accepted beat with TLAST.
  - CRC→IDLE when the CRC beat loads into the output register.
- Handshake:
  - S_AXIS_TREADY = (state!=CRC) && (!M_AXIS_TVALID || M_AXIS_TREADY).
  - The output register advances only when !M_AXIS_TVALID || M_AXIS_TREADY.
  - Stalled outputs hold DATA, LAST and ABORT stable.
- Latency: one cycle from input accept to output valid.
  - The CRC beat loads the cycle after the last data beat leaves the input, provided the output slot is free.
  - A 1-dword FIS therefore yields 2 output beats on back-to-back cycles with no stall.
- Data beat:
  - M_AXIS_TDATA = S_AXIS_TDATA ^ prn, or S_AXIS_TDATA when scrambling is disabled.
  - M_AXIS_TLAST = 0.
  - crc ← crc32(crc, S_AXIS_TDATA). The CRC covers the unscrambled data.
  - fill advances 32 LFSR steps.
- LFSR step, identical to the receiver: prn[k] = fill[15] for k=0..31 in order; fill ← {fill[14:0],0} ^ (fill[15] ? POLYNOMIAL : 0).
- CRC beat:
  - M_AXIS_TDATA = crc ^ prn (the next LFSR dword), M_AXIS_TLAST = 1.
  - Afterwards fill ← INITIAL (or 0 when scrambling is disabled) and crc ← CRC_INIT.
- CRC update: 32 serial shifts, MSB of data first. No final XOR and no bit reflection.
- When idle with no valid input, fill tracks i_cfg_scrambler_en (INITIAL/0). The config is sampled only between frames and is stable within a frame.
- Abort:
  - Honoured when S_AXIS_TABORT && (!S_AXIS_TVALID || S_AXIS_TREADY) while state==DATA.
  - On abort: M_AXIS_TABORT=1 at the next output slot; that beat has M_AXIS_TVALID=0.
  - M_AXIS_TABORT stays high while a stalled valid beat is pending. It never falls while M_AXIS_TVALID && !M_AXIS_TREADY.
  - On abort: state→IDLE and fill/crc reinitialise. No CRC is emitted.
  - Abort in IDLE is dropped, with no output.
  - Abort in CRC state is ignored: the source has already completed the frame, and the CRC is still sent.
- Abort takes priority over a simultaneous valid beat; that beat is discarded.

Decomposition:
- Shared package satatx_pkg: SATA_SCRAMBLER_POLY, SATA_SCRAMBLER_SEED, SATA_CRC_POLY, SATA_CRC_INIT.
  - Also holds the scramble() and crc32_step() functions, shared with the receive descrambler and the receive CRC checker.
- One sub-module is natural: sata_crc32, a combinational dword CRC next-state used by both the TX block and the RX checker.
- The state machine and LFSR live in the top module.

Test Plan:
- Scrambler enabled, 1-dword FIS 0x00000000, TLAST, no stalls → beat0 = 0xC2D2768D with TLAST=0; beat1 = CRC ^ 0x1F26B368 with TLAST=1.
- Scrambler disabled, random 5-dword FIS → 6 beats: beats 0–4 equal the input, beat 5 equals the model CRC. Running the CRC over all 6 dwords gives residue 0x00000000.
- Random M_AXIS_TREADY backpressure over 20 back-to-back FIS → outputs stable while stalled. S_AXIS_TREADY=0 for exactly the CRC-pending cycle(s). Each frame restarts at prn 0xC2D2768D.
- Abort after 3 dwords of an 8-dword FIS → M_AXIS_TABORT pulse, no TLAST/CRC beat. The next FIS first dword scrambles with 0xC2D2768D.
- Abort in IDLE, and abort asserted in the cycle after TLAST acceptance → no M_AXIS_TABORT; the CRC beat is still emitted.
- Reset asserted mid-frame with M_AXIS_TVALID high and TREADY low → next cycle all outputs 0. The first post-reset frame matches the model.

Source files
------------

// File: rtl/satatx_pkg.sv
// Shared SATA link-layer constants and the scrambler / CRC helpers used by both
// the transmit framer and the receive descrambler/checker.
package satatx_pkg;

  localparam logic [15:0] SATA_SCRAMBLER_POLY = 16'ha011;
  localparam logic [15:0] SATA_SCRAMBLER_SEED = 16'hffff;
  localparam logic [31:0] SATA_CRC_POLY       = 32'h04c11db7;
  localparam logic [31:0] SATA_CRC_INIT       = 32'h52325032;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StData = 2'd1,
    StCrc  = 2'd2
  } tx_state_e;

  typedef struct packed {
    logic [31:0] prn;
    logic [15:0] fill;
  } scramble_t;

  // 32 LFSR steps: first generated bit lands in prn[0].
  function automatic scramble_t scramble(input logic [15:0] fill, input logic [15:0] poly);
    scramble_t   res;
    logic [15:0] f;
    f       = fill;
    res.prn = '0;
    for (int k = 0; k < 32; k++) begin
      res.prn[k] = f[15];
      f          = {f[14:0], 1'b0} ^ (f[15] ? poly : 16'h0000);
    end
    res.fill = f;
    return res;
  endfunction

  // Serial CRC-32 over one dword, data MSB first, no reflection, no final XOR.
  function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic [31:0] data,
                                             input logic [31:0] poly);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      fb = c[31] ^ data[i];
      c  = {c[30:0], 1'b0} ^ (fb ? poly : 32'h0000_0000);
    end
    return c;
  endfunction

endpackage

// File: rtl/sata_crc32.sv
// Combinational dword CRC-32 next-state, shared by the TX framer and RX checker.
module sata_crc32
  import satatx_pkg::*;
#(
  parameter logic [31:0] Poly = SATA_CRC_POLY
) (
  input  logic [31:0] crc_i,
  input  logic [31:0] data_i,
  output logic [31:0] crc_o
);

  // Fold one full data dword into the running CRC.
  always_comb begin
    crc_o = crc32_step(crc_i, data_i, Poly);
  end

endmodule

// File: rtl/satatx_crc_scrambler.sv
// SATA TX frame stage: CRC-32 over raw FIS dwords, CRC appended as the last
// beat, data and CRC scrambled with the 16-bit link LFSR.
module satatx_crc_scrambler
  import satatx_pkg::*;
#(
  parameter logic [15:0] POLYNOMIAL   = SATA_SCRAMBLER_POLY,
  parameter logic [15:0] INITIAL      = SATA_SCRAMBLER_SEED,
  parameter logic [31:0] CRC_POLY     = SATA_CRC_POLY,
  parameter logic [31:0] CRC_INIT     = SATA_CRC_INIT,
  parameter bit          OPT_LOWPOWER = 1'b1
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESET,
  input  logic        i_cfg_scrambler_en,
  input  logic        S_AXIS_TVALID,
  output logic        S_AXIS_TREADY,
  input  logic [31:0] S_AXIS_TDATA,
  input  logic        S_AXIS_TLAST,
  input  logic        S_AXIS_TABORT,
  output logic        M_AXIS_TVALID,
  input  logic        M_AXIS_TREADY,
  output logic [31:0] M_AXIS_TDATA,
  output logic        M_AXIS_TLAST,
  output logic        M_AXIS_TABORT
);

  tx_state_e   state_q, state_d;
  logic [15:0] fill_q, fill_d;
  logic [31:0] crc_q, crc_d, crc_next;
  logic        abort_pend_q, abort_pend_d;
  logic        m_valid_q, m_valid_d;
  logic        m_last_q, m_last_d;
  logic        m_abort_q, m_abort_d;
  logic [31:0] m_data_q, m_data_d;

  logic        out_ready, accept, abort_req, abort_now;
  logic [31:0] prn_gated;
  logic [15:0] fill_restart;
  scramble_t   scr;

  sata_crc32 #(
    .Poly (CRC_POLY)
  ) u_crc (
    .crc_i  (crc_q),
    .data_i (S_AXIS_TDATA),
    .crc_o  (crc_next)
  );

  assign out_ready     = !m_valid_q || M_AXIS_TREADY;
  assign S_AXIS_TREADY = (state_q != StCrc) && out_ready;
  assign accept        = S_AXIS_TVALID && S_AXIS_TREADY;

  // An abort seen while the output slot is busy is held until the slot frees up;
  // any beat offered in that cycle is swallowed by the abort.
  assign abort_req    = (state_q == StData) &&
                        (abort_pend_q || (S_AXIS_TABORT && (!S_AXIS_TVALID || S_AXIS_TREADY)));
  assign abort_now    = abort_req && out_ready;
  assign abort_pend_d = abort_req && !out_ready;

  // Next scrambler dword from the current fill; disabled scrambling passes data through.
  always_comb begin
    scr          = scramble(fill_q, POLYNOMIAL);
    prn_gated    = i_cfg_scrambler_en ? scr.prn : 32'h0000_0000;
    fill_restart = i_cfg_scrambler_en ? INITIAL : 16'h0000;
  end

  // Frame FSM, LFSR/CRC advance and output register load.
  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    crc_d     = crc_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_abort_d = m_abort_q;
    m_data_d  = m_data_q;

    if (state_q == StIdle && !S_AXIS_TVALID) begin
      fill_d = fill_restart;
    end

    if (out_ready) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
      m_abort_d = 1'b0;
      m_data_d  = OPT_LOWPOWER ? 32'h0000_0000 : m_data_q;
      if (abort_now) begin
        m_abort_d = 1'b1;
        state_d   = StIdle;
        fill_d    = fill_restart;
        crc_d     = CRC_INIT;
      end else if (state_q == StCrc) begin
        m_valid_d = 1'b1;
        m_last_d  = 1'b1;
        m_data_d  = crc_q ^ prn_gated;
        state_d   = StIdle;
        fill_d    = fill_restart;
        crc_d     = CRC_INIT;
      end else if (accept) begin
        m_valid_d = 1'b1;
        m_data_d  = S_AXIS_TDATA ^ prn_gated;
        crc_d     = crc_next;
        fill_d    = scr.fill;
        state_d   = S_AXIS_TLAST ? StCrc : StData;
      end
    end
  end

  // State and output registers, synchronous reset drops any partial frame.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state_q      <= StIdle;
      fill_q       <= INITIAL;
      crc_q        <= CRC_INIT;
      abort_pend_q <= 1'b0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      m_abort_q    <= 1'b0;
      m_data_q     <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      fill_q       <= fill_d;
      crc_q        <= crc_d;
      abort_pend_q <= abort_pend_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      m_abort_q    <= m_abort_d;
      m_data_q     <= m_data_d;
    end
  end

  assign M_AXIS_TVALID = m_valid_q;
  assign M_AXIS_TLAST  = m_last_q;
  assign M_AXIS_TABORT = m_abort_q;
  assign M_AXIS_TDATA  = m_data_q;

endmodule

// File: tb/tb_satatx_crc_scrambler.sv
// Randomized bench for the SATA TX CRC/scrambler stage with a frame-level model.
module tb_satatx_crc_scrambler;

  localparam logic [31:0] PRN0     = 32'hc2d2768d;
  localparam logic [31:0] PRN1     = 32'h1f26b368;
  localparam logic [31:0] C_POLY   = 32'h04c11db7;
  localparam logic [31:0] C_INIT   = 32'h52325032;
  localparam int          MaxWords = 64;

  logic        clk;
  logic        rst;
  logic        cfg_en;
  logic        s_valid, s_ready, s_last, s_abort;
  logic [31:0] s_data;
  logic        m_valid, m_ready, m_last, m_abort;
  logic [31:0] m_data;

  int total = 0;
  int bad   = 0;
  int bp_mode;  // 0: always ready, 1: random, 2: never ready
  int cyc = 0;

  logic [31:0] prn_tab [MaxWords];

  // Model / scoreboard state
  logic [31:0] exp_data[$];
  bit          exp_last[$];
  logic [31:0] frame_words[$];
  bit          crc_pend;
  int          exp_aborts, obs_aborts;
  logic [31:0] obs_data[$];
  bit          obs_last[$];
  int          obs_cyc[$];
  bit          prev_stall;
  logic [31:0] stall_data;
  logic        stall_last, stall_abort;

  satatx_crc_scrambler dut (
    .S_AXI_ACLK         (clk),
    .S_AXI_ARESET       (rst),
    .i_cfg_scrambler_en (cfg_en),
    .S_AXIS_TVALID      (s_valid),
    .S_AXIS_TREADY      (s_ready),
    .S_AXIS_TDATA       (s_data),
    .S_AXIS_TLAST       (s_last),
    .S_AXIS_TABORT      (s_abort),
    .M_AXIS_TVALID      (m_valid),
    .M_AXIS_TREADY      (m_ready),
    .M_AXIS_TDATA       (m_data),
    .M_AXIS_TLAST       (m_last),
    .M_AXIS_TABORT      (m_abort)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // Frame CRC as polynomial long division: (init*x^N + M*x^32) mod G.
  function automatic logic [31:0] crc_of(input logic [31:0] w[$]);
    bit          b[$];
    logic [31:0] init, poly, r;
    int          n;
    init = C_INIT;
    poly = C_POLY;
    n    = w.size() * 32;
    foreach (w[k]) for (int i = 31; i >= 0; i--) b.push_back(w[k][i]);
    for (int i = 0; i < 32; i++) b[i] = b[i] ^ init[31-i];
    repeat (32) b.push_back(1'b0);
    for (int i = 0; i < n; i++)
      if (b[i]) for (int j = 1; j <= 32; j++) b[i+j] = b[i+j] ^ poly[32-j];
    for (int i = 0; i < 32; i++) r[31-i] = b[n+i];
    return r;
  endfunction

  // Downstream backpressure
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ($urandom_range(0, 3) != 0);
        default: m_ready = 1'b0;
      endcase
    end
  end

  // Monitor and scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      exp_data.delete();
      exp_last.delete();
      frame_words.delete();
      crc_pend   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(m_valid), 1);
        check("stall_data", m_data, stall_data);
        check("stall_last", 32'(m_last), 32'(stall_last));
        check("stall_abort", 32'(m_abort), 32'(stall_abort));
      end
      check("s_tready", 32'(s_ready), 32'(!crc_pend && (!m_valid || m_ready)));
      if (m_abort && !m_valid) obs_aborts++;
      if (m_valid && m_ready) begin
        obs_data.push_back(m_data);
        obs_last.push_back(m_last);
        obs_cyc.push_back(cyc);
        if (exp_data.size() == 0) check("unexpected_beat", 32'(m_data), 32'hxxxx_xxxx);
        else begin
          check("m_tdata", m_data, exp_data.pop_front());
          check("m_tlast", 32'(m_last), 32'(exp_last.pop_front()));
        end
      end
      if (s_abort && frame_words.size() != 0 && (!s_valid || s_ready) && (!m_valid || m_ready)) begin
        exp_aborts++;
        frame_words.delete();
      end else if (s_valid && s_ready) begin
        exp_data.push_back(s_data ^ (cfg_en ? prn_tab[frame_words.size()] : 32'h0));
        exp_last.push_back(1'b0);
        frame_words.push_back(s_data);
        if (s_last) begin
          exp_data.push_back(crc_of(frame_words) ^ (cfg_en ? prn_tab[frame_words.size()] : 32'h0));
          exp_last.push_back(1'b1);
          frame_words.delete();
          crc_pend = 1'b1;
        end
      end else if (crc_pend && (!m_valid || m_ready)) begin
        crc_pend = 1'b0;
      end
      prev_stall  = m_valid && !m_ready;
      stall_data  = m_data;
      stall_last  = m_last;
      stall_abort = m_abort;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input bit last);
    int guard;
    bit acc;
    guard   = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    do begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 300);
    if (!acc) check("send_timeout", 0, 1);
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 32'h0;
  endtask

  task automatic send_frame(input int n);
    for (int i = 0; i < n; i++) send_word($urandom, i == n - 1);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_data.size() != 0 || m_valid || crc_pend) && guard < 1000) begin
      step(1);
      guard++;
    end
    if (guard >= 1000) check("drain_timeout", 32'(exp_data.size()), 0);
    step(2);
  endtask

  task automatic clear_obs();
    obs_data.delete();
    obs_last.delete();
    obs_cyc.delete();
    exp_aborts = 0;
    obs_aborts = 0;
  endtask

  function automatic int count_last();
    int c;
    c = 0;
    foreach (obs_last[i]) if (obs_last[i]) c++;
    return c;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1);
  end

  initial begin
    logic [15:0] f;
    logic [31:0] w[$];
    logic [31:0] sent[$];
    logic [31:0] d;

    // Scrambler bit stream, packed first-bit-into-bit-0
    f = 16'hffff;
    for (int k = 0; k < MaxWords; k++)
      for (int b = 0; b < 32; b++) begin
        prn_tab[k][b] = f[15];
        f = {f[14:0], 1'b0} ^ (f[15] ? 16'ha011 : 16'h0000);
      end

    rst = 1'b1; cfg_en = 1'b1; bp_mode = 0;
    s_valid = 1'b0; s_last = 1'b0; s_abort = 1'b0; s_data = 32'h0;
    clear_obs();

    step(3);
    @(negedge clk);
    check("rst_valid", 32'(m_valid), 0);
    check("rst_abort", 32'(m_abort), 0);
    check("rst_last", 32'(m_last), 0);
    check("rst_data", m_data, 0);
    check("rst_tready", 32'(s_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    step(2);

    // 1-dword FIS of zero, scrambled
    send_word(32'h0, 1'b1);
    drain();
    w.delete(); w.push_back(32'h0);
    check("t1_beats", 32'(obs_data.size()), 2);
    if (obs_data.size() == 2) begin
      check("t1_beat0", obs_data[0], PRN0);
      check("t1_last0", 32'(obs_last[0]), 0);
      check("t1_crc_prn", obs_data[1] ^ crc_of(w), PRN1);
      check("t1_last1", 32'(obs_last[1]), 1);
      check("t1_b2b", 32'(obs_cyc[1] - obs_cyc[0]), 1);
    end

    // Unscrambled 5-dword FIS, CRC residue over all six beats
    cfg_en = 1'b0;
    step(3);
    clear_obs();
    sent.delete();
    for (int i = 0; i < 5; i++) begin
      d = $urandom;
      sent.push_back(d);
      send_word(d, i == 4);
    end
    drain();
    check("t2_beats", 32'(obs_data.size()), 6);
    if (obs_data.size() == 6) begin
      for (int i = 0; i < 5; i++) check("t2_passthru", obs_data[i], sent[i]);
      check("t2_crc", obs_data[5], crc_of(sent));
      check("t2_residue", crc_of(obs_data), 0);
    end

    // 20 back-to-back frames under random backpressure
    cfg_en = 1'b1;
    step(3);
    clear_obs();
    bp_mode = 1;
    for (int i = 0; i < 20; i++) send_frame($urandom_range(1, 8));
    drain();
    bp_mode = 0;
    step(2);
    check("t3_frames", 32'(count_last()), 20);

    // Abort after 3 of 8 dwords, then a fresh frame
    clear_obs();
    for (int i = 0; i < 3; i++) send_word($urandom, 1'b0);
    s_abort = 1'b1;
    step(1);
    s_abort = 1'b0;
    step(3);
    d = $urandom;
    send_word(d, 1'b0);
    send_word($urandom, 1'b1);
    drain();
    check("t4_abort_pulses", 32'(obs_aborts), 1);
    check("t4_abort_model", 32'(obs_aborts), 32'(exp_aborts));
    check("t4_lasts", 32'(count_last()), 1);
    check("t4_beats", 32'(obs_data.size()), 6);
    if (obs_data.size() == 6) check("t4_restart_prn", obs_data[3] ^ d, PRN0);

    // Abort in IDLE and right after TLAST: ignored
    clear_obs();
    s_abort = 1'b1;
    step(1);
    s_abort = 1'b0;
    step(2);
    send_word($urandom, 1'b0);
    send_word($urandom, 1'b1);
    s_abort = 1'b1;
    step(1);
    s_abort = 1'b0;
    drain();
    check("t5_no_abort", 32'(obs_aborts), 0);
    check("t5_lasts", 32'(count_last()), 1);
    check("t5_beats", 32'(obs_data.size()), 3);

    // Reset mid-frame with a stalled valid beat
    bp_mode = 2;
    step(2);
    send_word($urandom, 1'b0);
    step(2);
    check("t6_stalled", 32'(m_valid), 1);
    rst = 1'b1;
    step(1);
    check("t6_rst_valid", 32'(m_valid), 0);
    check("t6_rst_data", m_data, 0);
    check("t6_rst_last", 32'(m_last), 0);
    check("t6_rst_abort", 32'(m_abort), 0);
    rst = 1'b0;
    bp_mode = 0;
    step(2);
    clear_obs();
    d = $urandom;
    send_word(d, 1'b0);
    send_frame(2);
    drain();
    check("t6_beats", 32'(obs_data.size()), 4);
    if (obs_data.size() == 4) check("t6_first_prn", obs_data[0] ^ d, PRN0);
    check("t6_no_abort", 32'(obs_aborts), 0);
    check("final_queue", 32'(exp_data.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
